golomb_k_calc: RTL and testbench
================================

Name:
golomb_k_calc

Overview:
- Computes the LOCO-I / JPEG-LS Golomb coding parameter k from a context's accumulated error magnitude A and occurrence count N.
- k is the smallest value such that (N << k) >= A.
- Used by the run-mode and regular-mode coding stages.
- Provides a combinational k for same-cycle use, plus a registered copy with a valid flag for pipelined consumers.

Parameters:
- KMAX, 15: saturation value of k, and the largest k searched. Must fit in 4 bits.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-low reset.
- en  input  1  input-valid strobe; captures the current result into k_reg.
- N_Q  input  7  context count N, unsigned.
- A_Q  input  13  context accumulated |error| A, unsigned.
- k  output  4  combinational Golomb parameter for the current N_Q/A_Q.
- k_reg  output  4  registered k.
- valid_out  output  1  high for one cycle after a cycle in which en was high.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Combinational path (k):
  - k = min{ j in 0..KMAX : (N_Q << j) >= A_Q }.
  - Compare at at least 29 bits (13 + 16); no truncation of the shifted N.
  - No clock or reset dependency.
  - Exactly equivalent to the loop: for k=0; (N<<k) < A; k++.
  - A_Q = 0: k = 0 for any N_Q, including N_Q = 0.
  - N_Q = 0 and A_Q > 0: no j satisfies the condition; k = KMAX (15).
  - For legal N_Q >= 1, k never exceeds 13; the bound case is N=1, A=8191.
  - Recommended implementation: priority encoder over 16 parallel comparators, or an equivalent leading-one computation.
- Registered path, on the rising edge of clk:
  - reset = 0: k_reg <= 0, valid_out <= 0. Reset has priority over en.
  - Else if en = 1: k_reg <= k (the combinational value for the current inputs), valid_out <= 1.
  - Else: k_reg holds its value, valid_out <= 0.
- Latency: k is available in 0 cycles; k_reg and valid_out in 1 cycle.
- Back-to-back en: a new result every cycle, valid_out stays high.
- Reset asserted mid-stream: the next edge clears both registers regardless of en.
- No other state; no handshake back-pressure.

Test Plan:
- Boundaries: N=1,A=1 -> k=0. N=4,A=16 -> k=2. N=4,A=17 -> k=3.
- Saturation and zero: N=1,A=8191 -> k=13. N=64,A=8191 -> k=7. N=0,A=5 -> k=15. N=0,A=0 -> k=0. N=127,A=0 -> k=0.
- Reset: hold reset=0 with en=1 and N=1,A=100 -> after the edge k_reg=0, valid_out=0. Release reset -> the next edge gives k_reg=7, valid_out=1.
- Pipelining: en high for 3 consecutive cycles with (N,A) = (2,3), (2,9), (5,5) -> k_reg = 1, 3, 0 on successive edges, valid_out high for 3 cycles. Then en=0 -> k_reg holds 0 and valid_out=0.
- Random: 10k random N in 0..127 and A in 0..8191 -> k matches the loop model, and k_reg equals the previous cycle's k whenever en was high.

Source files
------------

// File: rtl/golomb_k_calc.sv
`default_nettype none
// ============================================================================
//  Module      : golomb_k_calc
//  Description : LOCO-I / JPEG-LS Golomb parameter computation.
//                k = min{ j in 0..KMAX : (N_Q << j) >= A_Q }, saturating at
//                KMAX when no j qualifies (only possible for N_Q = 0, A_Q > 0).
//                The combinational k is available in the same cycle; a
//                registered copy with a one-cycle valid flag is also provided
//                for pipelined consumers.
//  Ports       :
//      clk        in   1   rising-edge clock
//      reset      in   1   synchronous, active-low reset
//      en         in   1   input-valid strobe, captures k into k_reg
//      N_Q        in   7   context occurrence count N (unsigned)
//      A_Q        in  13   context accumulated |error| A (unsigned)
//      k          out  4   combinational Golomb parameter
//      k_reg      out  4   registered k
//      valid_out  out  1   high for one cycle after a cycle with en high
//  Revision    : 1.0  initial release
// ============================================================================
module golomb_k_calc #(
    parameter int KMAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [6:0]  N_Q,
    input  logic [12:0] A_Q,
    output logic [3:0]  k,
    output logic [3:0]  k_reg,
    output logic        valid_out
);

    // Width wide enough that N shifted by the largest k is never truncated
    // and the comparison against A is exact.
    localparam int c_CW = 29;

    // One comparator per candidate shift: w_ge[j] = ((N << j) >= A).
    logic [KMAX:0] w_ge;

    genvar gj;
    generate
        for (gj = 0; gj <= KMAX; gj++) begin : g_cmp
            logic [c_CW-1:0] w_nshift;
            assign w_nshift = {{(c_CW-7){1'b0}}, N_Q} << gj;
            assign w_ge[gj] = (w_nshift >= {{(c_CW-13){1'b0}}, A_Q});
        end
    endgenerate

    // Priority encoder: lowest set comparator wins. Scanning from the top
    // down lets the smallest qualifying j overwrite larger ones. With no
    // comparator set the result saturates at KMAX.
    logic [3:0] w_k;

    always_comb begin
        w_k = 4'(KMAX);
        for (int j = KMAX; j >= 0; j--) begin
            if (w_ge[j]) begin
                w_k = 4'(j);
            end
        end
    end

    assign k = w_k;

    // Registered copy; reset takes priority over en.
    logic [3:0] r_k;
    logic       r_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_k     <= 4'd0;
            r_valid <= 1'b0;
        end else if (en) begin
            r_k     <= w_k;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign k_reg     = r_k;
    assign valid_out = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_golomb_k_calc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_golomb_k_calc
//  Description : Self-checking bench for golomb_k_calc. Directed boundary,
//                reset and pipelining cases followed by randomized stimulus
//                checked against a loop-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_golomb_k_calc;

    localparam int KMAX = 15;

    logic        clk;
    logic        reset;
    logic        en;
    logic [6:0]  N_Q;
    logic [12:0] A_Q;
    logic [3:0]  k;
    logic [3:0]  k_reg;
    logic        valid_out;

    int total;
    int bad;
    int exp_kreg;
    int exp_valid;

    golomb_k_calc #(.KMAX(KMAX)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .N_Q       (N_Q),
        .A_Q       (A_Q),
        .k         (k),
        .k_reg     (k_reg),
        .valid_out (valid_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: the textbook loop, bounded by the saturation value.
    function automatic int ref_k(input int n, input int a);
        int kk;
        kk = 0;
        while (kk < KMAX && (longint'(n) << kk) < longint'(a)) kk++;
        return kk;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        if (obs != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Apply one cycle of stimulus: check the combinational k, then after the
    // edge check the registered outputs against the expected register state.
    task automatic drive(input logic rn, input logic e, input int n, input int a,
                         input string tag);
        logic [31:0] nv;
        logic [31:0] av;
        int          rk;
        nv    = n;
        av    = a;
        reset = rn;
        en    = e;
        N_Q   = nv[6:0];
        A_Q   = av[12:0];
        rk    = ref_k(n, a);
        #1;
        chk({tag, "_k"}, int'(k), rk);
        if (!rn) begin
            exp_kreg  = 0;
            exp_valid = 0;
        end else if (e) begin
            exp_kreg  = rk;
            exp_valid = 1;
        end else begin
            exp_valid = 0;
        end
        @(posedge clk);
        #1;
        chk({tag, "_kreg"}, int'(k_reg), exp_kreg);
        chk({tag, "_valid"}, int'(valid_out), exp_valid);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_kreg  = 0;
        exp_valid = 0;
        reset     = 1'b0;
        en        = 1'b0;
        N_Q       = '0;
        A_Q       = '0;

        // Reset state
        drive(1'b0, 1'b0, 3, 3, "rst0");
        drive(1'b0, 1'b1, 1, 100, "rst_en");
        drive(1'b1, 1'b1, 1, 100, "rst_rel");
        chk("rst_rel_k7", int'(k_reg), 7);

        // Boundaries, saturation and zero cases
        drive(1'b1, 1'b1, 1, 1, "n1a1");
        chk("n1a1_abs", int'(k_reg), 0);
        drive(1'b1, 1'b1, 4, 16, "n4a16");
        chk("n4a16_abs", int'(k_reg), 2);
        drive(1'b1, 1'b1, 4, 17, "n4a17");
        chk("n4a17_abs", int'(k_reg), 3);
        drive(1'b1, 1'b1, 1, 8191, "n1amax");
        chk("n1amax_abs", int'(k_reg), 13);
        drive(1'b1, 1'b1, 64, 8191, "n64amax");
        chk("n64amax_abs", int'(k_reg), 7);
        drive(1'b1, 1'b1, 0, 5, "n0a5");
        chk("n0a5_abs", int'(k_reg), 15);
        drive(1'b1, 1'b1, 0, 0, "n0a0");
        chk("n0a0_abs", int'(k_reg), 0);
        drive(1'b1, 1'b1, 127, 0, "n127a0");
        chk("n127a0_abs", int'(k_reg), 0);

        // Pipelining: back-to-back en, then hold
        drive(1'b1, 1'b1, 2, 3, "pipe0");
        chk("pipe0_abs", int'(k_reg), 1);
        drive(1'b1, 1'b1, 2, 9, "pipe1");
        chk("pipe1_abs", int'(k_reg), 3);
        drive(1'b1, 1'b1, 5, 5, "pipe2");
        chk("pipe2_abs", int'(k_reg), 0);
        drive(1'b1, 1'b0, 100, 8000, "hold");
        chk("hold_abs", int'(k_reg), 0);
        chk("hold_v", int'(valid_out), 0);

        // Randomized stimulus with occasional mid-stream reset
        for (int i = 0; i < 10000; i++) begin
            logic rn;
            logic e;
            rn = ($urandom_range(0, 63) != 0);
            e  = ($urandom_range(0, 3) != 0);
            drive(rn, e, int'($urandom_range(0, 127)), int'($urandom_range(0, 8191)), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
